sid_osc: RTL

- Per-voice oscillator and register front end of the MOS6581 voice. It is the producer side of the waveform generator interface.
- Holds the voice's frequency, pulse-width and control registers, which the CPU writes over a byte bus.
- Advances a 24-bit phase accumulator and a 23-bit noise LFSR once per chip tick.
- Supplies the waveform generator with acc, lfsr, pw, waveform selects and ring. Supplies the neighbouring voice with sync and ring sources.

---
 rtl/sid_pkg.sv | 32 +++
 rtl/sid_lfsr.sv | 37 +++
 rtl/sid_osc.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sid_pkg.sv
// Shared constants for the SID voice front end.
//   - CPU register indices for one voice (0..6)
//   - control register bit positions
//   - noise LFSR reset seed and feedback taps
//   - accumulator bit that clocks the noise LFSR
package sid_pkg;

  localparam logic [2:0] SID_FREQ_LO = 3'd0;
  localparam logic [2:0] SID_FREQ_HI = 3'd1;
  localparam logic [2:0] SID_PW_LO   = 3'd2;
  localparam logic [2:0] SID_PW_HI   = 3'd3;
  localparam logic [2:0] SID_CTRL    = 3'd4;
  localparam logic [2:0] SID_AD      = 3'd5;
  localparam logic [2:0] SID_SR      = 3'd6;

  localparam int CTRL_GATE  = 0;
  localparam int CTRL_SYNC  = 1;
  localparam int CTRL_RING  = 2;
  localparam int CTRL_TEST  = 3;
  localparam int CTRL_TRI   = 4;
  localparam int CTRL_SAW   = 5;
  localparam int CTRL_PULSE = 6;
  localparam int CTRL_NOISE = 7;

  localparam logic [22:0] SID_LFSR_SEED = 23'h7FFFF8;
  localparam int LFSR_TAP_A = 22;
  localparam int LFSR_TAP_B = 17;

  // A 0->1 transition on this accumulator bit clocks the noise LFSR.
  localparam int ACC_NOISE_BIT = 19;

endpackage

// File: rtl/sid_lfsr.sv
// Noise shift register of one SID voice.
//   clk   : system clock
//   reset : synchronous, active-high; loads SEED
//   load  : reload SEED (test bit held on a tick)
//   step  : advance one position (accumulator noise-bit edge)
//   state : current register contents
module sid_lfsr
  import sid_pkg::*;
#(
  parameter int            W    = 23,
  parameter logic [W-1:0]  SEED = SID_LFSR_SEED
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load)
      state_d = SEED;
    else if (step)
      state_d = {state_q[W-2:0], state_q[LFSR_TAP_A] ^ state_q[LFSR_TAP_B]};
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEED;
    else       state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/sid_osc.sv
// SID voice oscillator and register front end.
// Holds freq / pulse-width / control registers written over a byte bus and
// advances the phase accumulator and noise LFSR on each chip tick (clk_en).
//   clk, reset        : clock, synchronous active-high reset
//   clk_en            : one-clk chip tick
//   wr_en/addr/data   : CPU register write port (addr 0..6; 5..7 ignored)
//   sync_in           : msb_rising of the preceding voice
//   acc, lfsr, pw     : accumulator, noise register, pulse width
//   noise..triangle   : waveform selects (control bits 7..4)
//   ring, gate        : control bits 2 and 0
//   msb_rising        : acc MSB went 0->1 on the last tick (registered)
module sid_osc
  import sid_pkg::*;
#(
  parameter int                 ACC_W     = 24,
  parameter int                 LFSR_W    = 23,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = SID_LFSR_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              sync_in,
  output logic [ACC_W-1:0]  acc,
  output logic [LFSR_W-1:0] lfsr,
  output logic [11:0]       pw,
  output logic              noise,
  output logic              pulse,
  output logic              saw,
  output logic              triangle,
  output logic              ring,
  output logic              gate,
  output logic              msb_rising
);

  logic [15:0]      freq_q, freq_d;
  logic [11:0]      pw_q,   pw_d;
  logic [7:0]       ctrl_q, ctrl_d;
  logic [ACC_W-1:0] acc_q,  acc_d, acc_sum;
  logic             msb_q,  msb_d;
  logic             lfsr_load, lfsr_step;

  // Register file. Ticks read the _q values, so a write landing on the same
  // clk as clk_en only takes effect from the following tick.
  always_comb begin
    freq_d = freq_q;
    pw_d   = pw_q;
    ctrl_d = ctrl_q;
    if (wr_en) begin
      case (wr_addr)
        SID_FREQ_LO: freq_d[7:0]  = wr_data;
        SID_FREQ_HI: freq_d[15:8] = wr_data;
        SID_PW_LO:   pw_d[7:0]    = wr_data;
        SID_PW_HI:   pw_d[11:8]   = wr_data[3:0];
        SID_CTRL:    ctrl_d       = wr_data;
        default: ;  // AD/SR and addr 7 live elsewhere
      endcase
    end
  end

  assign acc_sum = acc_q + {{(ACC_W-16){1'b0}}, freq_q};

  // Tick update: test beats hard sync beats normal accumulation.
  always_comb begin
    acc_d     = acc_q;
    msb_d     = msb_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (clk_en) begin
      if (ctrl_q[CTRL_TEST]) begin
        acc_d     = '0;
        msb_d     = 1'b0;
        lfsr_load = 1'b1;
      end else if (ctrl_q[CTRL_SYNC] && sync_in) begin
        acc_d = '0;
        msb_d = 1'b0;
      end else begin
        acc_d     = acc_sum;
        msb_d     = ~acc_q[ACC_W-1] & acc_sum[ACC_W-1];
        lfsr_step = ~acc_q[ACC_NOISE_BIT] & acc_sum[ACC_NOISE_BIT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      freq_q <= '0;
      pw_q   <= '0;
      ctrl_q <= '0;
      acc_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      freq_q <= freq_d;
      pw_q   <= pw_d;
      ctrl_q <= ctrl_d;
      acc_q  <= acc_d;
      msb_q  <= msb_d;
    end
  end

  sid_lfsr #(.W(LFSR_W), .SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .state (lfsr)
  );

  assign acc        = acc_q;
  assign pw         = pw_q;
  assign noise      = ctrl_q[CTRL_NOISE];
  assign pulse      = ctrl_q[CTRL_PULSE];
  assign saw        = ctrl_q[CTRL_SAW];
  assign triangle   = ctrl_q[CTRL_TRI];
  assign ring       = ctrl_q[CTRL_RING];
  assign gate       = ctrl_q[CTRL_GATE];
  assign msb_rising = msb_q;

endmodule
